rf_wr_arbiter: RTL and testbench

Shares the single register-file write port (w_reg/w_data/RegWrite) between two writeback requesters: port 0 (ALU/pipeline writeback) and port 1 (long-latency unit, e.g. load or multiply). Each port has a small input FIFO with valid/ready handshake. An arbiter drains one entry per cycle into a registered write stage that drives the register file directly. A pending-write scoreboard answers two combinational hazard queries for the decode stage.

---
 rtl/rf_wr_arbiter_pkg.sv | 19 +
 rtl/rf_wr_fifo.sv | 95 +++++++++
 rtl/rf_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_rf_wr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wr_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Holds the data width, the register-index width and the XZR index used by every file of the block.
package rf_wr_arbiter_pkg;

    localparam int unsigned RF_WORD  = 64;
    localparam int unsigned RF_REG_W = 5;

    typedef logic [RF_REG_W-1:0] reg_idx_t;

    localparam reg_idx_t RF_XZR = 5'd31;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic logic is_xzr(input reg_idx_t r);
        return r == RF_XZR;
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO of {reg, data} write requests.
// Every valid entry's register index is exposed so the top level can check for hazards.
module rf_wr_fifo
    import rf_wr_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned WORD       = RF_WORD
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push,
    input  logic [RF_REG_W-1:0]                  push_reg,
    input  logic [WORD-1:0]                      push_data,
    input  logic                                 pop,
    output logic                                 full,
    output logic                                 empty,
    output logic [RF_REG_W-1:0]                  head_reg,
    output logic [WORD-1:0]                      head_data,
    output logic [FIFO_DEPTH-1:0]                ent_valid,
    output logic [FIFO_DEPTH-1:0][RF_REG_W-1:0]  ent_reg
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [RF_REG_W-1:0]   mem_reg_q  [FIFO_DEPTH];
    logic [WORD-1:0]       mem_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        count_q, count_d;
    logic                  do_push, do_pop;

    // full comes only from the registered count, so a full FIFO never accepts
    // even when it is popped in the same cycle
    assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head_reg  = mem_reg_q[rd_ptr_q];
    assign head_data = mem_data_q[rd_ptr_q];
    assign ent_valid = valid_q;

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            ent_reg[i] = mem_reg_q[i];
        end
    end

    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (do_push) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg_q[i]  <= '0;
                mem_data_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_reg_q[wr_ptr_q]  <= push_reg;
            mem_data_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Two-port writeback arbiter in front of the single register-file write port, with a hazard scoreboard.
// Define RF_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int unsigned WORD       = RF_WORD,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [RF_REG_W-1:0] req0_reg,
    input  logic [WORD-1:0]     req0_data,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [RF_REG_W-1:0] req1_reg,
    input  logic [WORD-1:0]     req1_data,
    output logic                RegWrite,
    output logic [RF_REG_W-1:0] w_reg,
    output logic [WORD-1:0]     w_data,
    input  logic [RF_REG_W-1:0] q_reg1,
    input  logic [RF_REG_W-1:0] q_reg2,
    output logic                q_busy1,
    output logic                q_busy2,
    output logic                idle
);

    logic                                full0, full1, empty0, empty1;
    logic                                push0, push1, grant0, grant1, prio0;
    logic [RF_REG_W-1:0]                 head0_reg, head1_reg;
    logic [WORD-1:0]                     head0_data, head1_data;
    logic [FIFO_DEPTH-1:0]               ent0_valid, ent1_valid;
    logic [FIFO_DEPTH-1:0][RF_REG_W-1:0] ent0_reg, ent1_reg;
    logic                                reg_write_q;
    logic [RF_REG_W-1:0]                 w_reg_q;
    logic [WORD-1:0]                     w_data_q;

    assign req0_ready = ~full0;
    assign req1_ready = ~full1;

    // XZR writes complete the handshake but are never stored
    assign push0 = req0_valid & ~full0 & ~is_xzr(req0_reg);
    assign push1 = req1_valid & ~full1 & ~is_xzr(req1_reg);

    rf_wr_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WORD       (WORD)
    ) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_reg  (req0_reg),
        .push_data (req0_data),
        .pop       (grant0),
        .full      (full0),
        .empty     (empty0),
        .head_reg  (head0_reg),
        .head_data (head0_data),
        .ent_valid (ent0_valid),
        .ent_reg   (ent0_reg)
    );

    rf_wr_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WORD       (WORD)
    ) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_reg  (req1_reg),
        .push_data (req1_data),
        .pop       (grant1),
        .full      (full1),
        .empty     (empty1),
        .head_reg  (head1_reg),
        .head_data (head1_data),
        .ent_valid (ent1_valid),
        .ent_reg   (ent1_reg)
    );

`ifdef RF_ARB_RR_EN
    logic last_grant_q;

    // resets to port 1 so port 0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT1;
        end else if (grant0 | grant1) begin
            last_grant_q <= grant1 ? PORT1 : PORT0;
        end
    end

    assign prio0 = (last_grant_q == PORT1);
`else
    assign prio0 = 1'b1;
`endif

    assign grant0 = ~empty0 & (empty1 | prio0);
    assign grant1 = ~empty1 & ~grant0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q <= 1'b0;
            w_reg_q     <= '0;
            w_data_q    <= '0;
        end else begin
            reg_write_q <= grant0 | grant1;
            if (grant0 | grant1) begin
                w_reg_q  <= grant1 ? head1_reg : head0_reg;
                w_data_q <= grant1 ? head1_data : head0_data;
            end
        end
    end

    assign RegWrite = reg_write_q;
    assign w_reg    = w_reg_q;
    assign w_data   = w_data_q;
    assign idle     = empty0 & empty1 & ~reg_write_q;

    always_comb begin
        q_busy1 = reg_write_q && (w_reg_q == q_reg1);
        q_busy2 = reg_write_q && (w_reg_q == q_reg2);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent0_valid[i] && (ent0_reg[i] == q_reg1)) q_busy1 = 1'b1;
            if (ent1_valid[i] && (ent1_reg[i] == q_reg1)) q_busy1 = 1'b1;
            if (ent0_valid[i] && (ent0_reg[i] == q_reg2)) q_busy2 = 1'b1;
            if (ent1_valid[i] && (ent1_reg[i] == q_reg2)) q_busy2 = 1'b1;
        end
        if (is_xzr(q_reg1)) q_busy1 = 1'b0;
        if (is_xzr(q_reg2)) q_busy2 = 1'b0;
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed self-checking bench for rf_wr_arbiter.
// Expected write order follows RF_ARB_RR_EN when it is defined for the build.
module tb_rf_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_reg = '0, req1_reg = '0;
    logic [63:0] req0_data = '0, req1_data = '0;
    logic        RegWrite;
    logic [4:0]  w_reg;
    logic [63:0] w_data;
    logic [4:0]  q_reg1 = '0, q_reg2 = '0;
    logic        q_busy1, q_busy2, idle;

    int total = 0;
    int bad = 0;

    logic [4:0]  src0[$], src1[$];
    logic [4:0]  obs_reg[$];
    logic [63:0] obs_data[$];
    int          obs_cyc[$];
    logic        mon_en = 1'b0;
    int          cyc_cnt = 0;
    int          first_stall1;

    rf_wr_arbiter #(
        .WORD       (64),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_reg   (req0_reg),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_reg   (req1_reg),
        .req1_data  (req1_data),
        .RegWrite   (RegWrite),
        .w_reg      (w_reg),
        .w_data     (w_data),
        .q_reg1     (q_reg1),
        .q_reg2     (q_reg2),
        .q_busy1    (q_busy1),
        .q_busy2    (q_busy2),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mon_en && RegWrite) begin
            obs_reg.push_back(w_reg);
            obs_data.push_back(w_data);
            obs_cyc.push_back(cyc_cnt);
        end
    end

    function automatic logic [63:0] data_of(input logic [4:0] r);
        return {32'hCAFE0000 | {27'd0, r}, 27'd0, r};
    endfunction

    // Streams src0/src1 through the handshake one attempt per cycle, then waits for idle.
    task automatic run_streams(input int budget);
        logic r0, r1;
        int   acc1 = 0;
        first_stall1 = -1;
        for (int c = 0; c < budget; c++) begin
            if (src0.size() == 0 && src1.size() == 0) break;
            @(negedge clk);
            req0_valid = (src0.size() > 0);
            req1_valid = (src1.size() > 0);
            if (req0_valid) begin req0_reg = src0[0]; req0_data = data_of(src0[0]); end
            if (req1_valid) begin req1_reg = src1[0]; req1_data = data_of(src1[0]); end
            r0 = req0_ready;
            r1 = req1_ready;
            if (req1_valid && !r1 && first_stall1 < 0) first_stall1 = acc1;
            @(posedge clk);
            if (req0_valid && r0) void'(src0.pop_front());
            if (req1_valid && r1) begin void'(src1.pop_front()); acc1++; end
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        total++;
        if (src0.size() + src1.size() != 0) begin
            bad++;
            $display("FAIL stream_accept_timeout left=%0d required=0", src0.size() + src1.size());
        end
        for (int c = 0; c < 40; c++) begin
            if (idle) break;
            @(negedge clk);
        end
        total++;
        if (idle !== 1'b1) begin
            bad++;
            $display("FAIL drain_idle_timeout idle=%b required=1", idle);
        end
    endtask

    task automatic clear_obs();
        obs_reg.delete();
        obs_data.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL rst_regwrite got=%b exp=0", RegWrite); end
        total++; if (w_reg !== 5'd0) begin bad++; $display("FAIL rst_w_reg got=%0d exp=0", w_reg); end
        total++; if (w_data !== 64'd0) begin bad++; $display("FAIL rst_w_data got=%h exp=0", w_data); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b exp=1", idle); end
        total++;
        if ({req0_ready, req1_ready} !== 2'b11) begin
            bad++; $display("FAIL rst_ready got=%b exp=11", {req0_ready, req1_ready});
        end
        total++;
        if ({q_busy1, q_busy2} !== 2'b00) begin
            bad++; $display("FAIL rst_busy got=%b exp=00", {q_busy1, q_busy2});
        end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 64'h1234;
        q_reg1 = 5'd5; q_reg2 = 5'd6;
        #1;
        total++; if (q_busy1 !== 1'b0) begin bad++; $display("FAIL sw_busy_pre got=%b exp=0", q_busy1); end
        @(negedge clk);
        req0_valid = 1'b0;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL sw_t0_regwrite got=%b exp=0", RegWrite); end
        total++; if (q_busy1 !== 1'b1) begin bad++; $display("FAIL sw_t0_busy got=%b exp=1", q_busy1); end
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL sw_t0_idle got=%b exp=0", idle); end
        @(negedge clk);
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL sw_t1_regwrite got=%b exp=1", RegWrite); end
        total++; if (w_reg !== 5'd5) begin bad++; $display("FAIL sw_t1_w_reg got=%0d exp=5", w_reg); end
        total++; if (w_data !== 64'h1234) begin bad++; $display("FAIL sw_t1_w_data got=%h exp=1234", w_data); end
        total++; if (q_busy1 !== 1'b1) begin bad++; $display("FAIL sw_t1_busy got=%b exp=1", q_busy1); end
        total++; if (q_busy2 !== 1'b0) begin bad++; $display("FAIL sw_t1_busy2 got=%b exp=0", q_busy2); end
        @(negedge clk);
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL sw_t2_regwrite got=%b exp=0", RegWrite); end
        total++; if (q_busy1 !== 1'b0) begin bad++; $display("FAIL sw_t2_busy got=%b exp=0", q_busy1); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL sw_t2_idle got=%b exp=1", idle); end
        total++; if (w_reg !== 5'd5) begin bad++; $display("FAIL sw_t2_w_reg_hold got=%0d exp=5", w_reg); end
    endtask

    task automatic test_xzr_drop();
        @(negedge clk);
        req1_valid = 1'b1; req1_reg = 5'd31; req1_data = 64'hFFFF;
        q_reg2 = 5'd31;
        #1;
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL xzr_ready got=%b exp=1", req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0;
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL xzr_idle got=%b exp=1", idle); end
        total++; if (q_busy2 !== 1'b0) begin bad++; $display("FAIL xzr_busy got=%b exp=0", q_busy2); end
        @(negedge clk);
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL xzr_regwrite got=%b exp=0", RegWrite); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL xzr_idle2 got=%b exp=1", idle); end
        q_reg2 = 5'd0;
    endtask

    task automatic test_contention();
        logic [4:0] exp_order[6];
`ifdef RF_ARB_RR_EN
        exp_order = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13};
`else
        exp_order = '{5'd1, 5'd2, 5'd3, 5'd11, 5'd12, 5'd13};
`endif
        clear_obs();
        src0 = '{5'd1, 5'd2, 5'd3};
        src1 = '{5'd11, 5'd12, 5'd13};
        mon_en = 1'b1;
        run_streams(50);
        mon_en = 1'b0;
        total++;
        if (obs_reg.size() != 6) begin
            bad++; $display("FAIL cont_count got=%0d exp=6", obs_reg.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (obs_reg[i] !== exp_order[i]) begin
                    bad++; $display("FAIL cont_order[%0d] got=%0d exp=%0d", i, obs_reg[i], exp_order[i]);
                end
                total++;
                if (obs_data[i] !== data_of(exp_order[i])) begin
                    bad++; $display("FAIL cont_data[%0d] got=%h exp=%h", i, obs_data[i], data_of(exp_order[i]));
                end
                total++;
                if (obs_cyc[i] != obs_cyc[0] + i) begin
                    bad++; $display("FAIL cont_back_to_back[%0d] got=%0d exp=%0d", i, obs_cyc[i], obs_cyc[0] + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n0 = 0, n1 = 0;
        clear_obs();
        src0 = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
        src1 = '{5'd20, 5'd21, 5'd22};
        mon_en = 1'b1;
        run_streams(60);
        mon_en = 1'b0;
        total++;
        if (first_stall1 != 2) begin
            bad++; $display("FAIL bp_stall_after got=%0d exp=2", first_stall1);
        end
        total++;
        if (obs_reg.size() != 9) begin
            bad++; $display("FAIL bp_count got=%0d exp=9", obs_reg.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                total++;
                if (obs_reg[i] < 5'd20) begin
                    if (obs_reg[i] !== 5'(n0 + 1)) begin
                        bad++; $display("FAIL bp_port0_seq[%0d] got=%0d exp=%0d", i, obs_reg[i], n0 + 1);
                    end
                    n0++;
                end else begin
                    if (obs_reg[i] !== 5'(20 + n1)) begin
                        bad++; $display("FAIL bp_port1_seq[%0d] got=%0d exp=%0d", i, obs_reg[i], 20 + n1);
                    end
                    n1++;
                end
            end
`ifndef RF_ARB_RR_EN
            total++;
            if (obs_reg[6] !== 5'd20) begin
                bad++; $display("FAIL bp_fixed_starve got=%0d exp=20", obs_reg[6]);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        int writes = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req0_valid = 1'b1; req0_reg = 5'(7 + c); req0_data = data_of(5'(7 + c));
            req1_valid = 1'b1; req1_reg = 5'(20 + c); req1_data = data_of(5'(20 + c));
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        q_reg1 = 5'd21;
        #1;
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL rm_pre_regwrite got=%b exp=1", RegWrite); end
        total++; if (q_busy1 !== 1'b1) begin bad++; $display("FAIL rm_pre_busy got=%b exp=1", q_busy1); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL rm_pre_full got=%b exp=0", req1_ready); end
        rst_n = 1'b0;
        #1;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL rm_regwrite got=%b exp=0", RegWrite); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL rm_idle got=%b exp=1", idle); end
        total++;
        if ({req0_ready, req1_ready} !== 2'b11) begin
            bad++; $display("FAIL rm_ready got=%b exp=11", {req0_ready, req1_ready});
        end
        total++; if (q_busy1 !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", q_busy1); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (RegWrite) writes++;
        end
        total++; if (writes != 0) begin bad++; $display("FAIL rm_no_writes got=%0d exp=0", writes); end
        q_reg1 = 5'd0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_xzr_drop();
        test_contention();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
